// File: rtl/instr_fetch_queue_pkg.sv
// Shared CPU front-end constants and types.
//   ADDR_W / INSTR_W    : PC and instruction word widths
//   DEFAULT_RESET_PC    : fetch PC after reset unless overridden
//   PC_INC              : sequential PC step in bytes
//   NOP                 : filler instruction word
//   fetch_entry_t       : {pc, instr} pair stored in fetch FIFOs
//   pc_plus4()          : sequential successor PC, wraps at 32 bits
package instr_fetch_queue_pkg;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned INSTR_W = 32;

   localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [ADDR_W-1:0]  PC_INC           = 32'd4;
   localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] pc_plus4(input logic [ADDR_W-1:0] pc);
      return pc + PC_INC;
   endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch front-end bus bundle: instruction-memory req/gnt/rvalid channel, redirect
// input from branch resolution and the valid/ready hand-off toward decode.
//   master : the fetch unit (drives imem request and decode-side outputs)
//   slave  : the environment (memory, branch unit, decode)
interface instr_fetch_queue_if;
   import instr_fetch_queue_pkg::*;

   logic                imem_req_o;
   logic [ADDR_W-1:0]   imem_addr_o;
   logic                imem_gnt_i;
   logic                imem_rvalid_i;
   logic [INSTR_W-1:0]  imem_rdata_i;
   logic                redirect_i;
   logic [ADDR_W-1:0]   redirect_pc_i;
   logic                if_valid_o;
   logic [INSTR_W-1:0]  if_instr_o;
   logic [ADDR_W-1:0]   if_pc_o;
   logic [ADDR_W-1:0]   if_pc4_o;
   logic                id_ready_i;

   modport master (
      output imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o, if_pc4_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, id_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o, if_pc4_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, id_ready_i
   );

endinterface

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with flush.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (accepted when not full, or full with a pop this cycle)
//   pop      : drop the head entry (ignored when empty)
//   flush    : discard all entries; overrides push and pop
//   wdata    : entry to write
//   rdata    : head entry, read straight from the storage registers
//   count    : current occupancy, 0..DEPTH
//   full     : occupancy equals DEPTH
module instr_fetch_queue_fetch_fifo
   import instr_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic            flush,
   input  fetch_entry_t    wdata,
   output fetch_entry_t    rdata,
   output logic [CntW-1:0] count,
   output logic            full
);

   fetch_entry_t    mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            empty;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CntW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO may still accept a write when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end.
// Owns the fetch PC, issues in-order word fetches over a req/gnt channel, tags each
// request with its PC, buffers returned words and hands them to decode via valid/ready.
// A redirect flushes buffered work and discards every response still in flight.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : fetch bus bundle (master side), see instr_fetch_queue_if
// Parameters:
//   DEPTH    : queue entries and max outstanding requests (power of 2, >= 2)
//   RESET_PC : fetch PC after reset
module instr_fetch_queue
   import instr_fetch_queue_pkg::*;
#(
   parameter int unsigned       DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input logic                 clk_i,
   input logic                 rst_i,
   instr_fetch_queue_if.master bus
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;
   localparam int unsigned SumW = CntW + 1;

   logic [ADDR_W-1:0] fpc_q;
   logic [ADDR_W-1:0] fpc_d;
   logic [CntW-1:0]   inflight_q;
   logic [CntW-1:0]   inflight_d;
   logic [CntW-1:0]   drop_q;
   logic [CntW-1:0]   drop_d;

   logic              redirect;
   logic              req;
   logic              issue;
   logic              resp;
   logic              accept;
   logic              valid;
   logic              pop;
   logic [SumW-1:0]   used;

   fetch_entry_t      tag_wdata;
   fetch_entry_t      tag_head;
   logic [CntW-1:0]   tag_count;
   logic              tag_full;

   fetch_entry_t      q_wdata;
   fetch_entry_t      q_head;
   logic [CntW-1:0]   q_count;
   logic              q_full;

   assign redirect = bus.redirect_i;

   // Responses with no matching request are ignored.
   assign resp   = bus.imem_rvalid_i & (inflight_q != '0);
   // Words owed to a pre-redirect stream are discarded, as is any word in the redirect cycle.
   assign accept = resp & (drop_q == '0) & ~redirect;

   assign valid = (q_count != '0);
   assign pop   = valid & bus.id_ready_i & ~redirect;

   // Slots committed to buffered words plus outstanding requests. The head leaving this
   // cycle frees its slot immediately, which keeps a 1-cycle memory streaming at full rate.
   assign used  = SumW'(q_count) + SumW'(inflight_q) - SumW'(pop);
   assign req   = ~rst_i & ~redirect & (used < SumW'(DEPTH));
   assign issue = req & bus.imem_gnt_i;

   always_comb begin
      fpc_d      = fpc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      if (redirect) begin
         fpc_d      = bus.redirect_pc_i & ~32'h3;
         inflight_d = inflight_q - CntW'(resp);
         drop_d     = inflight_q - CntW'(resp);
      end else begin
         if (issue) begin
            fpc_d = pc_plus4(fpc_q);
         end
         inflight_d = inflight_q + CntW'(issue) - CntW'(resp);
         if (resp && (drop_q != '0)) begin
            drop_d = drop_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fpc_q      <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         fpc_q      <= fpc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   // PC of each live request, in issue order; consumed only by accepted responses.
   assign tag_wdata = '{pc: fpc_q, instr: NOP};

   instr_fetch_queue_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (issue),
      .pop   (accept),
      .flush (redirect),
      .wdata (tag_wdata),
      .rdata (tag_head),
      .count (tag_count),
      .full  (tag_full)
   );

   assign q_wdata = '{pc: tag_head.pc, instr: bus.imem_rdata_i};

   instr_fetch_queue_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_instr_queue (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (accept),
      .pop   (pop),
      .flush (redirect),
      .wdata (q_wdata),
      .rdata (q_head),
      .count (q_count),
      .full  (q_full)
   );

   assign bus.imem_req_o  = req;
   assign bus.imem_addr_o = fpc_q;
   assign bus.if_valid_o  = valid;
   assign bus.if_instr_o  = valid ? q_head.instr : NOP;
   assign bus.if_pc_o     = valid ? q_head.pc : '0;
   assign bus.if_pc4_o    = pc_plus4(bus.if_pc_o);

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(accept && q_full && !pop))
            else $error("instruction queue written while full");
         assert (!(bus.imem_rvalid_i && (inflight_q == '0)))
            else $error("imem response with no request outstanding");
         assert (!(accept && (tag_count == '0)))
            else $error("accepted response has no PC tag");
         assert (!(issue && tag_full))
            else $error("PC tag FIFO written while full");
         assert (!accept || (tag_head.instr == NOP))
            else $error("PC tag FIFO entry carries data");
      end
   end
`endif

endmodule
